// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder with a start/done handshake.
//
// One full-adder cell plus a carry flip-flop process the operands LSB first,
// one bit per clock. The sum bits are collected in a result shift register.
// The modulo-2^WIDTH sum and the carry-out are then presented on registered
// outputs.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   start  request an addition (only looked at in IDLE)
//   a, b   operands, captured on the edge that accepts start
//   out    (a+b) mod 2^WIDTH, updated on the final RUN edge
//   cout   carry out of the MSB, updated with out
//   busy   high while the serial addition is running
//   done   one-cycle pulse when out/cout have just been updated
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa, sb, res, res_next;
  logic             c, c_next, s, last;
  logic [CW-1:0]    cnt;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  assign s      = fa_sum(sa[0], sb[0], c);
  assign c_next = fa_carry(sa[0], sb[0], c);
  assign last   = (cnt == LAST);

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign res_next = (res >> 1) | (WIDTH'(s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Control and visible result: cleared by reset. out/cout hold until the
  // final RUN edge of the next operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      c    <= 1'b0;
      cnt  <= '0;
      out  <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            c   <= 1'b0;
            cnt <= '0;
          end
        end
        RUN: begin
          c <= c_next;
          if (last) begin
            out  <= res_next;
            cout <= c_next;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and partial-sum shift registers: pure datapath, no reset needed
  // because they are always reloaded on an accepted start.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sa  <= a;
      sb  <= b;
      res <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= res_next;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized, scoreboard-checked bench for serial_adder.
// Expected sums come from plain integer addition of the operands; a monitor
// process pops them whenever done pulses.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] a, b;
  logic [W-1:0] out;
  logic         cout, busy, done;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .out   (out),
    .cout  (cout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  logic [W:0] exp_q[$];
  logic [W:0] held;
  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals a result.
  always @(negedge clk) begin
    check("busy_done_exclusive", 32'(busy & done), 32'd0);
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with sum %0d, expected no done", {cout, out});
      end else begin
        check("sum", 32'({cout, out}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Called in IDLE, just after a rising edge. If poke is set, start is
  // pulsed again during RUN and must be ignored.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    int n, busy_n;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back((W+1)'(x) + (W+1)'(y));
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 0;
    busy_n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      start = poke && (n == 2);
      if (busy) begin
        busy_n++;
        check("hold_during_run", 32'({cout, out}), 32'(held));
      end
      if (done) break;
      if (n > 40) begin
        check("done_timeout", 32'(n), 32'(W + 1));
        break;
      end
    end
    start = 1'b0;
    check("done_latency", 32'(n), 32'(W + 1));
    check("busy_cycles", 32'(busy_n), 32'(W));
    held = (W+1)'(x) + (W+1)'(y);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, t1, t2, d0;
    reset = 1'b1;
    start = 1'b1;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(out), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    held = '0;

    run_op(4'd3, 4'd5, 1'b0);
    run_op(4'd15, 4'd1, 1'b0);
    run_op(4'd15, 4'd15, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_after_done", 32'({cout, out}), 32'(held));
    run_op(4'd6, 4'd7, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back with start held high.
    a = 4'd2;
    b = 4'd9;
    start = 1'b1;
    exp_q.push_back(5'd11);
    exp_q.push_back(5'd20);
    @(posedge clk);
    #1;
    a = 4'd10;
    b = 4'd10;
    n = 0;
    t1 = 0;
    t2 = 0;
    while (t2 == 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (t1 == 0) t1 = n;
        else t2 = n;
      end
      if (n == W + 3) start = 1'b0;
    end
    check("b2b_first_latency", 32'(t1), 32'(W + 1));
    check("b2b_period", 32'(t2 - t1), 32'(W + 2));
    held = 5'd20;
    @(posedge clk);
    #1;

    // Reset during the second RUN cycle.
    a = 4'd12;
    b = 4'd12;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(5'd24);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_out", 32'(out), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    held = '0;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    @(posedge clk);
    #1;
    run_op(4'd1, 4'd1, 1'b0);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(W'(i), W'(j), 1'b0);

    for (int k = 0; k < 30; k++)
      run_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
